tx_os_scheduler: RTL and testbench
==================================

Name: tx_os_scheduler

Overview:
Schedules the shared TX ordered-set generator and the TX data/OS mux between three sources: LTSSM ordered-set requests, periodic SKP insertion, and LPIF FIFO data in L0. It sits between the TX LTSSM, the OS generator and the LPIF TX FIFO. It owns OSGeneratorStart, OSType, HoldFIFOData and MuxSel so that only one source drives the lane at a time.

Parameters:
SKP_INTERVAL, 1180, Pclk cycles between SKP scheduling ticks
CNT_WIDTH, 12, SKP interval counter width (must hold SKP_INTERVAL-1)
MAX_PENDING_SKP, 3, saturation value of the pending-SKP counter
OS_TIMEOUT, 255, max cycles in WAIT_OS before abort

Ports:
Pclk  in  1  clock
Reset  in  1  asynchronous, active-low reset
SkpEnable  in  1  enables the SKP interval counter
LtssmOSReq  in  1  level; LTSSM requests one OS of LtssmOSType
LtssmOSType  in  3  TS1=000, TS2=001, EIOS=010, IDLE=100
LtssmOSGrant  out  1  one-cycle pulse when the LTSSM request is accepted
L0Active  in  1  link in L0, data transfer allowed
FIFOReady  in  1  LPIF TX FIFO has data
PacketBoundary  in  1  current data symbol ends a packet
OSType  out  3  type presented to the OS generator; SKP=011
OSGeneratorStart  out  1  one-cycle start pulse
OSGeneratorBusy  in  1  generator busy
OSGeneratorFinish  in  1  one-cycle pulse at OS end
HoldFIFOData  out  1  1 = stall LPIF FIFO
MuxSel  out  1  0 = OS path, 1 = data path
SkpPending  out  2  pending SKP count
OSTimeoutErr  out  1  one-cycle pulse on WAIT_OS abort

Behaviour:
- Reset (async assert, sync release): state=IDLE, HoldFIFOData=1, all other outputs 0, counters 0. Every output is registered.
- SKP counter: increments each cycle while SkpEnable=1. At SKP_INTERVAL-1 it wraps to 0 and raises a tick. A tick increments SkpPending, saturating at MAX_PENDING_SKP.
- SkpEnable=0 clears both the interval counter and SkpPending in the next cycle.
- When a tick and an SKP completion occur in the same cycle, SkpPending is unchanged.
- States: IDLE, DATA, DRAIN, WAIT_OS.
- IDLE (MuxSel=0, HoldFIFOData=1). Priority order, evaluated only when OSGeneratorBusy=0:
  1. SkpPending>0: OSType<=011, OSGeneratorStart<=1, go to WAIT_OS, mark the current OS as SKP.
  2. LtssmOSReq: OSType<=LtssmOSType, OSGeneratorStart<=1, LtssmOSGrant<=1, go to WAIT_OS.
  3. L0Active && FIFOReady: go to DATA.
  - Start and Grant appear exactly one cycle after the deciding IDLE cycle.
- DATA (MuxSel=1, HoldFIFOData=0):
  - L0Active=0 → DRAIN.
  - SkpPending>0 && PacketBoundary → DRAIN.
  - Otherwise stay. No SKP is inserted mid-packet.
- DRAIN: one cycle with HoldFIFOData=1 and MuxSel=1 to flush the in-flight symbol, then IDLE.
- WAIT_OS (MuxSel=0, HoldFIFOData=1): a cycle counter starts at 0.
  - OSGeneratorFinish → IDLE; if the OS was SKP, decrement SkpPending.
  - Counter reaching OS_TIMEOUT → pulse OSTimeoutErr, go to IDLE, SkpPending untouched, no retry bookkeeping.
- LtssmOSReq is held by the LTSSM until Grant. Grant is never issued twice for one OS.
- Reset asserted mid-operation forces all reset values immediately; any OS in progress is abandoned.

Test Plan:
- Reset=0 then release, SkpEnable=0, no requests → HoldFIFOData=1, MuxSel=0, Start never pulses.
- LtssmOSReq=1, type 001, Busy=0 → Start and Grant pulse together 1 cycle later, OSType=001. Finish after 16 cycles → IDLE, next request serviced.
- SKP_INTERVAL=8, SkpEnable=1, L0Active=1, FIFOReady=1, PacketBoundary every 5 cycles → DATA is left only on a boundary, DRAIN lasts 1 cycle, OSType=011, SkpPending returns to 0.
- Tick coincides with SKP Finish → SkpPending constant. Four ticks with no service → saturates at 3.
- SKP pending and LtssmOSReq in the same IDLE cycle → SKP issued first, Grant only after SKP Finish.
- Start issued but Finish withheld → OSTimeoutErr pulses 255 cycles after Start, state returns to IDLE. Reset asserted mid-WAIT_OS → outputs at reset values immediately.

Source files
------------

// File: rtl/tx_os_scheduler.sv
// Arbitrates the TX lane between LTSSM ordered sets, periodic SKP insertion and LPIF data.
// Owns the OS generator handshake and the data/OS mux so that only one source drives the lane.
module tx_os_scheduler #(
  parameter int SKP_INTERVAL    = 1180,
  parameter int CNT_WIDTH       = 12,
  parameter int MAX_PENDING_SKP = 3,
  parameter int OS_TIMEOUT      = 255
) (
  input  logic       Pclk,
  input  logic       Reset,
  input  logic       SkpEnable,
  input  logic       LtssmOSReq,
  input  logic [2:0] LtssmOSType,
  output logic       LtssmOSGrant,
  input  logic       L0Active,
  input  logic       FIFOReady,
  input  logic       PacketBoundary,
  output logic [2:0] OSType,
  output logic       OSGeneratorStart,
  input  logic       OSGeneratorBusy,
  input  logic       OSGeneratorFinish,
  output logic       HoldFIFOData,
  output logic       MuxSel,
  output logic [1:0] SkpPending,
  output logic       OSTimeoutErr
);

  localparam int TO_W = $clog2(OS_TIMEOUT + 1);

  localparam logic [CNT_WIDTH-1:0] SKP_LAST = CNT_WIDTH'(SKP_INTERVAL - 1);
  localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(OS_TIMEOUT - 1);
  localparam logic [1:0]           PEND_MAX = 2'(MAX_PENDING_SKP);
  localparam logic [2:0]           OS_SKP   = 3'b011;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DATA    = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_WAIT_OS = 2'd3;

  logic [1:0]           r_state;
  logic [CNT_WIDTH-1:0] r_skp_cnt;
  logic [1:0]           r_skp_pending;
  logic [TO_W-1:0]      r_to_cnt;
  logic                 r_os_is_skp;
  logic [2:0]           r_os_type;
  logic                 r_start;
  logic                 r_grant;
  logic                 r_err;
  logic                 r_hold;
  logic                 r_mux;

  logic [1:0]           w_state_next;
  logic [CNT_WIDTH-1:0] w_skp_cnt_next;
  logic [1:0]           w_pending_next;
  logic [TO_W-1:0]      w_to_cnt_next;
  logic                 w_os_is_skp_next;
  logic [2:0]           w_type_next;
  logic                 w_start_next;
  logic                 w_grant_next;
  logic                 w_err_next;
  logic                 w_tick;
  logic                 w_skp_done;

  assign w_tick     = SkpEnable && (r_skp_cnt == SKP_LAST);
  assign w_skp_done = (r_state == ST_WAIT_OS) && OSGeneratorFinish && r_os_is_skp;

  // A tick and an SKP completion in the same cycle cancel out.
  always_comb begin
    w_skp_cnt_next = r_skp_cnt;
    w_pending_next = r_skp_pending;
    if (!SkpEnable) begin
      w_skp_cnt_next = '0;
      w_pending_next = '0;
    end else begin
      w_skp_cnt_next = w_tick ? '0 : r_skp_cnt + CNT_WIDTH'(1);
      if (w_tick && !w_skp_done) begin
        if (r_skp_pending < PEND_MAX)
          w_pending_next = r_skp_pending + 2'd1;
      end else if (!w_tick && w_skp_done && (r_skp_pending != 2'd0)) begin
        w_pending_next = r_skp_pending - 2'd1;
      end
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_to_cnt_next    = '0;
    w_os_is_skp_next = r_os_is_skp;
    w_type_next      = r_os_type;
    w_start_next     = 1'b0;
    w_grant_next     = 1'b0;
    w_err_next       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!OSGeneratorBusy) begin
          if (r_skp_pending != 2'd0) begin
            w_state_next     = ST_WAIT_OS;
            w_type_next      = OS_SKP;
            w_start_next     = 1'b1;
            w_os_is_skp_next = 1'b1;
          end else if (LtssmOSReq) begin
            w_state_next     = ST_WAIT_OS;
            w_type_next      = LtssmOSType;
            w_start_next     = 1'b1;
            w_grant_next     = 1'b1;
            w_os_is_skp_next = 1'b0;
          end else if (L0Active && FIFOReady) begin
            w_state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        // SKP waits for a packet boundary so it never splits a packet.
        if (!L0Active || ((r_skp_pending != 2'd0) && PacketBoundary))
          w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_state_next = ST_IDLE;
      end
      ST_WAIT_OS: begin
        w_to_cnt_next = r_to_cnt + TO_W'(1);
        if (OSGeneratorFinish) begin
          w_state_next = ST_IDLE;
        end else if (r_to_cnt == TO_LAST) begin
          w_state_next = ST_IDLE;
          w_err_next   = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Pclk or negedge Reset) begin
    if (!Reset) begin
      r_state       <= ST_IDLE;
      r_skp_cnt     <= '0;
      r_skp_pending <= '0;
      r_to_cnt      <= '0;
      r_os_is_skp   <= 1'b0;
      r_os_type     <= '0;
      r_start       <= 1'b0;
      r_grant       <= 1'b0;
      r_err         <= 1'b0;
      r_hold        <= 1'b1;
      r_mux         <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_skp_cnt     <= w_skp_cnt_next;
      r_skp_pending <= w_pending_next;
      r_to_cnt      <= w_to_cnt_next;
      r_os_is_skp   <= w_os_is_skp_next;
      r_os_type     <= w_type_next;
      r_start       <= w_start_next;
      r_grant       <= w_grant_next;
      r_err         <= w_err_next;
      r_hold        <= (w_state_next != ST_DATA);
      r_mux         <= (w_state_next == ST_DATA) || (w_state_next == ST_DRAIN);
    end
  end

  assign LtssmOSGrant     = r_grant;
  assign OSType           = r_os_type;
  assign OSGeneratorStart = r_start;
  assign HoldFIFOData     = r_hold;
  assign MuxSel           = r_mux;
  assign SkpPending       = r_skp_pending;
  assign OSTimeoutErr     = r_err;

endmodule

// File: tb/tb_tx_os_scheduler.sv
// Randomized bench for tx_os_scheduler: LTSSM and OS generator behaviour is emulated and every
// output is compared each cycle against a transaction-level reference model.
module tb_tx_os_scheduler;

  localparam int SKP_INTERVAL = 8;
  localparam int CNT_WIDTH    = 4;
  localparam int MAX_PEND     = 3;
  localparam int OS_TIMEOUT   = 255;

  logic       Pclk;
  logic       Reset;
  logic       SkpEnable;
  logic       LtssmOSReq;
  logic [2:0] LtssmOSType;
  logic       LtssmOSGrant;
  logic       L0Active;
  logic       FIFOReady;
  logic       PacketBoundary;
  logic [2:0] OSType;
  logic       OSGeneratorStart;
  logic       OSGeneratorBusy;
  logic       OSGeneratorFinish;
  logic       HoldFIFOData;
  logic       MuxSel;
  logic [1:0] SkpPending;
  logic       OSTimeoutErr;

  tx_os_scheduler #(
    .SKP_INTERVAL   (SKP_INTERVAL),
    .CNT_WIDTH      (CNT_WIDTH),
    .MAX_PENDING_SKP(MAX_PEND),
    .OS_TIMEOUT     (OS_TIMEOUT)
  ) dut (
    .Pclk             (Pclk),
    .Reset            (Reset),
    .SkpEnable        (SkpEnable),
    .LtssmOSReq       (LtssmOSReq),
    .LtssmOSType      (LtssmOSType),
    .LtssmOSGrant     (LtssmOSGrant),
    .L0Active         (L0Active),
    .FIFOReady        (FIFOReady),
    .PacketBoundary   (PacketBoundary),
    .OSType           (OSType),
    .OSGeneratorStart (OSGeneratorStart),
    .OSGeneratorBusy  (OSGeneratorBusy),
    .OSGeneratorFinish(OSGeneratorFinish),
    .HoldFIFOData     (HoldFIFOData),
    .MuxSel           (MuxSel),
    .SkpPending       (SkpPending),
    .OSTimeoutErr     (OSTimeoutErr)
  );

  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: link mode as a name, SKP accounting as plain integers.
  string m_mode;
  int    m_pend, m_en, m_age, m_type;
  bit    m_os_skp, m_start, m_grant, m_err;

  function automatic void model_reset();
    m_mode = "idle"; m_pend = 0; m_en = 0; m_age = 0; m_type = 0;
    m_os_skp = 0; m_start = 0; m_grant = 0; m_err = 0;
  endfunction

  function automatic void model_step();
    int old_pend = m_pend;
    bit tick, done;
    tick = SkpEnable && ((m_en % SKP_INTERVAL) == SKP_INTERVAL - 1);
    done = (m_mode == "os") && OSGeneratorFinish && m_os_skp;
    m_start = 0; m_grant = 0; m_err = 0;
    if (m_mode == "idle") begin
      if (!OSGeneratorBusy) begin
        if (old_pend > 0) begin
          m_mode = "os"; m_age = 0; m_os_skp = 1; m_type = 3; m_start = 1;
        end else if (LtssmOSReq) begin
          m_mode = "os"; m_age = 0; m_os_skp = 0; m_type = int'(LtssmOSType);
          m_start = 1; m_grant = 1;
        end else if (L0Active && FIFOReady) begin
          m_mode = "data";
        end
      end
    end else if (m_mode == "data") begin
      if (!L0Active || (old_pend > 0 && PacketBoundary)) m_mode = "drain";
    end else if (m_mode == "drain") begin
      m_mode = "idle";
    end else begin
      if (OSGeneratorFinish) m_mode = "idle";
      else if (m_age == OS_TIMEOUT - 1) begin m_mode = "idle"; m_err = 1; end
      else m_age++;
    end
    m_en = SkpEnable ? m_en + 1 : 0;
    if (!SkpEnable) m_pend = 0;
    else begin
      m_pend = old_pend + int'(tick) - int'(done);
      if (m_pend > MAX_PEND) m_pend = MAX_PEND;
      if (m_pend < 0) m_pend = 0;
    end
  endfunction

  task automatic compare_outputs();
    check("MuxSel",           MuxSel,           (m_mode == "data") || (m_mode == "drain"));
    check("HoldFIFOData",     HoldFIFOData,     m_mode != "data");
    check("OSType",           OSType,           m_type);
    check("OSGeneratorStart", OSGeneratorStart, m_start);
    check("LtssmOSGrant",     LtssmOSGrant,     m_grant);
    check("SkpPending",       SkpPending,       m_pend);
    check("OSTimeoutErr",     OSTimeoutErr,     m_err);
  endtask

  task automatic check_reset_values();
    check("rst_HoldFIFOData", HoldFIFOData,     1);
    check("rst_MuxSel",       MuxSel,           0);
    check("rst_OSType",       OSType,           0);
    check("rst_Start",        OSGeneratorStart, 0);
    check("rst_Grant",        LtssmOSGrant,     0);
    check("rst_SkpPending",   SkpPending,       0);
    check("rst_TimeoutErr",   OSTimeoutErr,     0);
  endtask

  // Emulated LTSSM and OS generator.
  bit         req_on, gen_active, gen_silent, did_mid_reset;
  int         gen_left, pb_cnt;
  int         seen_err, seen_grant, seen_skp;
  logic [2:0] os_types [4] = '{3'b000, 3'b001, 3'b010, 3'b100};

  task automatic idle_inputs();
    SkpEnable = 0; LtssmOSReq = 0; LtssmOSType = 0; L0Active = 0; FIFOReady = 0;
    PacketBoundary = 0; OSGeneratorBusy = 0; OSGeneratorFinish = 0;
  endtask

  task automatic mid_reset();
    Reset = 0;
    #1;
    check_reset_values();
    model_reset();
    req_on = 0; gen_active = 0;
    idle_inputs();
    @(negedge Pclk);
    check_reset_values();
    Reset = 1;
    model_step();
  endtask

  task automatic run_cycles(input int n, input int phase);
    bit busy_now, force_busy;
    for (int i = 0; i < n; i++) begin
      @(negedge Pclk);
      compare_outputs();
      if (phase == 3 && i == n - 1) check("skp_saturation", SkpPending, MAX_PEND);
      if (OSTimeoutErr) begin gen_active = 0; seen_err++; end
      if (LtssmOSGrant) begin req_on = 0; seen_grant++; end
      if (OSGeneratorStart) begin
        $display("[%0t] os start type=%0d grant=%0d pending=%0d", $time, OSType,
                 LtssmOSGrant, SkpPending);
        if (OSType == 3'b011) seen_skp++;
        gen_active = 1;
        gen_left   = $urandom_range(1, 20);
        gen_silent = (phase == 4) || (phase == 5 && ($urandom % 40) == 0);
      end
      if (phase == 4 && !did_mid_reset && m_mode == "os" && m_age == 50) begin
        did_mid_reset = 1;
        mid_reset();
        continue;
      end
      force_busy = (phase == 3) || ((phase == 1 || phase == 5) && ($urandom % 10) == 0);
      case (phase)
        0: begin SkpEnable = 0; L0Active = 0; FIFOReady = 0; PacketBoundary = 0; end
        1: begin
          SkpEnable = 0; L0Active = ($urandom % 4) != 0; FIFOReady = $urandom % 2;
          PacketBoundary = ($urandom % 3) == 0;
        end
        2: begin
          SkpEnable = ($urandom % 20) != 0; L0Active = ($urandom % 20) != 0;
          FIFOReady = ($urandom % 8) != 0; PacketBoundary = (pb_cnt % 5) == 4;
        end
        3: begin SkpEnable = 1; L0Active = 0; FIFOReady = 0; PacketBoundary = 0; end
        4: begin
          SkpEnable = 0; L0Active = $urandom % 2; FIFOReady = $urandom % 2;
          PacketBoundary = $urandom % 2;
        end
        default: begin
          SkpEnable = ($urandom % 10) != 0; L0Active = ($urandom % 8) != 0;
          FIFOReady = $urandom % 2; PacketBoundary = ($urandom % 4) == 0;
        end
      endcase
      pb_cnt++;
      if (!req_on && phase != 0 && phase != 3 && ($urandom % 8) == 0) begin
        req_on = 1;
        LtssmOSType = os_types[$urandom_range(0, 3)];
      end
      LtssmOSReq = req_on;
      busy_now = gen_active;
      OSGeneratorFinish = 0;
      if (gen_active && !gen_silent) begin
        if (gen_left == 0) begin OSGeneratorFinish = 1; gen_active = 0; end
        else gen_left--;
      end
      OSGeneratorBusy = busy_now || force_busy;
      model_step();
    end
  endtask

  initial begin
    Reset = 0;
    idle_inputs();
    req_on = 0; gen_active = 0; gen_silent = 0; did_mid_reset = 0;
    gen_left = 0; pb_cnt = 0; seen_err = 0; seen_grant = 0; seen_skp = 0;
    model_reset();
    repeat (3) @(posedge Pclk);
    #1;
    check_reset_values();
    @(negedge Pclk);
    Reset = 1;
    model_step();
    run_cycles(20, 0);
    run_cycles(2000, 1);
    run_cycles(4000, 2);
    run_cycles(60, 3);
    run_cycles(1500, 4);
    run_cycles(4000, 5);
    check("saw_timeout", seen_err > 0, 1);
    check("saw_grant", seen_grant > 0, 1);
    check("saw_skp", seen_skp > 0, 1);
    check("saw_mid_reset", did_mid_reset, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
